// File: rtl/booth_mul_arbiter.sv
// Round-robin front end that time-shares one booth_top 16x16 multiplier between two
// requesters: accept an operand pair, pulse start, wait out the latency, return the product.
module booth_mul_arbiter #(
    parameter int unsigned MUL_LATENCY = 17
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [15:0] req0_a,
    input  logic [15:0] req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [15:0] req1_a,
    input  logic [15:0] req1_b,
    output logic        resp0_valid,
    input  logic        resp0_ready,
    output logic [32:0] resp0_product,
    output logic        resp1_valid,
    input  logic        resp1_ready,
    output logic [32:0] resp1_product,
    output logic        mul_start,
    output logic [15:0] mul_multiplicand,
    output logic [15:0] mul_multiplicator,
    input  logic [32:0] mul_product,
    output logic        busy
);
    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
    } mul_req_t;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;
    localparam logic [7:0] LAT_M1  = 8'(MUL_LATENCY - 1);

    logic [1:0]       state;
    logic             owner;
    logic             prio;
    logic [7:0]       cnt;
    logic [15:0]      op_a;
    logic [15:0]      op_b;
    logic [32:0]      result;
    logic             grant;
    logic             accept;
    logic             resp_hs;
    mul_req_t [1:0]   reqs;

    assign reqs[0] = '{a: req0_a, b: req0_b};
    assign reqs[1] = '{a: req1_a, b: req1_b};

    // A lone requester wins outright; prio only breaks ties. Ready is masked by the
    // reset input so nothing handshakes while reset is held.
    always_comb begin
        grant      = (req0_valid && req1_valid) ? prio : req1_valid;
        req0_ready = (state == S_IDLE) && !rst && req0_valid && !grant;
        req1_ready = (state == S_IDLE) && !rst && req1_valid && grant;
        accept     = req0_ready || req1_ready;
        resp_hs    = (state == S_RESP) && (owner ? resp1_ready : resp0_ready);
    end

    assign busy              = (state != S_IDLE);
    assign mul_start         = (state == S_ISSUE);
    assign mul_multiplicand  = op_a;
    assign mul_multiplicator = op_b;
    assign resp0_valid       = (state == S_RESP) && !owner;
    assign resp1_valid       = (state == S_RESP) && owner;
    assign resp0_product     = result;
    assign resp1_product     = result;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            owner  <= 1'b0;
            prio   <= 1'b0;
            cnt    <= 8'd0;
            op_a   <= 16'd0;
            op_b   <= 16'd0;
            result <= 33'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_a  <= reqs[grant].a;
                        op_b  <= reqs[grant].b;
                        owner <= grant;
                        state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    cnt   <= LAT_M1;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    // cnt reaches zero in the cycle the multiplier output becomes valid
                    if (cnt == 8'd0) begin
                        result <= mul_product;
                        state  <= S_RESP;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                default: begin
                    if (resp_hs) begin
                        prio  <= ~owner;
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Randomized and directed bench for booth_mul_arbiter against a transaction-level model
// of the arbitration rules, plus a multiplier stub whose product is valid for one cycle only.
module tb_booth_mul_arbiter;
    localparam int L = 17;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic [15:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic        resp0_ready = 1'b0, resp1_ready = 1'b0;
    logic        req0_ready, req1_ready, resp0_valid, resp1_valid, mul_start, busy;
    logic [32:0] resp0_product, resp1_product, mul_product = '0;
    logic [15:0] mul_multiplicand, mul_multiplicator;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [32:0] smul(input logic [15:0] a, input logic [15:0] b);
        logic signed [32:0] sa, sb;
        sa = $signed(a);
        sb = $signed(b);
        return sa * sb;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    booth_mul_arbiter #(.MUL_LATENCY(L)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_product(resp0_product),
        .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_product(resp1_product),
        .mul_start(mul_start), .mul_multiplicand(mul_multiplicand),
        .mul_multiplicator(mul_multiplicator), .mul_product(mul_product), .busy(busy)
    );

    // Multiplier stub: product is driven only in the cycle exactly L cycles after start.
    int          rem = -1;
    logic [32:0] pend = '0;
    always @(posedge clk) begin
        #1;
        if (rem >= 0) rem--;
        if (rst) rem = -1;
        else if (mul_start) begin
            rem  = L;
            pend = smul(mul_multiplicand, mul_multiplicator);
        end
        mul_product = (rem == 0) ? pend : {1'($urandom % 2), 32'($urandom)};
    end

    // Reference model: one operation in flight, tie goes to prio, prio flips after each response.
    typedef struct {
        bit          id;
        logic [15:0] a, b;
        logic [32:0] prod;
        int          acc;
    } op_t;
    op_t cur;
    bit  m_busy = 1'b0, prio_m = 1'b0, e_r0, e_r1, due;
    int  log_id[$];
    int  log_cyc[$];

    always @(negedge clk) begin
        if (rst) begin
            m_busy = 1'b0;
            prio_m = 1'b0;
        end else begin
            e_r0 = !m_busy && req0_valid && (!req1_valid || !prio_m);
            e_r1 = !m_busy && req1_valid && (!req0_valid || prio_m);
            due  = m_busy && (cyc >= cur.acc + L + 2);
            chk("busy", busy, m_busy);
            chk("req0_ready", req0_ready, e_r0);
            chk("req1_ready", req1_ready, e_r1);
            chk("mul_start", mul_start, m_busy && (cyc == cur.acc + 1));
            chk("resp0_valid", resp0_valid, due && !cur.id);
            chk("resp1_valid", resp1_valid, due && cur.id);
            if (due) begin
                chk("resp0_product", resp0_product, cur.prod);
                chk("resp1_product", resp1_product, cur.prod);
            end
            if (m_busy && cyc > cur.acc)
                chk("operands", {mul_multiplicand, mul_multiplicator}, {cur.a, cur.b});
            if (due && (cur.id ? resp1_ready : resp0_ready)) begin
                m_busy = 1'b0;
                prio_m = !cur.id;
            end else if (e_r0 || e_r1) begin
                cur.id   = e_r1;
                cur.a    = e_r1 ? req1_a : req0_a;
                cur.b    = e_r1 ? req1_b : req0_b;
                cur.prod = smul(cur.a, cur.b);
                cur.acc  = cyc;
                m_busy   = 1'b1;
                log_id.push_back(int'(e_r1));
                log_cyc.push_back(cyc);
            end
        end
    end

    // Latency sweep instances: multiplier modelled as a pure function of the operands.
    logic        sw_valid[2];
    logic [15:0] sw_a[2], sw_b[2], sw_mc[2], sw_mr[2];
    logic        sw_ready[2], sw_r1ready[2], sw_v0[2], sw_v1[2], sw_start[2], sw_busy[2];
    logic [32:0] sw_p0[2], sw_p1[2], sw_prod[2];
    assign sw_prod[0] = smul(sw_mc[0], sw_mr[0]);
    assign sw_prod[1] = smul(sw_mc[1], sw_mr[1]);

    booth_mul_arbiter #(.MUL_LATENCY(1)) u_l1 (
        .clk(clk), .rst(rst),
        .req0_valid(sw_valid[0]), .req0_ready(sw_ready[0]), .req0_a(sw_a[0]), .req0_b(sw_b[0]),
        .req1_valid(1'b0), .req1_ready(sw_r1ready[0]), .req1_a(16'd0), .req1_b(16'd0),
        .resp0_valid(sw_v0[0]), .resp0_ready(1'b1), .resp0_product(sw_p0[0]),
        .resp1_valid(sw_v1[0]), .resp1_ready(1'b1), .resp1_product(sw_p1[0]),
        .mul_start(sw_start[0]), .mul_multiplicand(sw_mc[0]), .mul_multiplicator(sw_mr[0]),
        .mul_product(sw_prod[0]), .busy(sw_busy[0])
    );

    booth_mul_arbiter #(.MUL_LATENCY(255)) u_l255 (
        .clk(clk), .rst(rst),
        .req0_valid(sw_valid[1]), .req0_ready(sw_ready[1]), .req0_a(sw_a[1]), .req0_b(sw_b[1]),
        .req1_valid(1'b0), .req1_ready(sw_r1ready[1]), .req1_a(16'd0), .req1_b(16'd0),
        .resp0_valid(sw_v0[1]), .resp0_ready(1'b1), .resp0_product(sw_p0[1]),
        .resp1_valid(sw_v1[1]), .resp1_ready(1'b1), .resp1_product(sw_p1[1]),
        .mul_start(sw_start[1]), .mul_multiplicand(sw_mc[1]), .mul_multiplicator(sw_mr[1]),
        .mul_product(sw_prod[1]), .busy(sw_busy[1])
    );

    task automatic do_req(input bit id, input logic [15:0] a, input logic [15:0] b, output int t);
        @(posedge clk); #1;
        if (id) begin req1_valid = 1'b1; req1_a = a; req1_b = b; end
        else    begin req0_valid = 1'b1; req0_a = a; req0_b = b; end
        t = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (id ? req1_ready : req0_ready) begin t = cyc; break; end
        end
        if (t < 0) chk("accept_timeout", 0, 1);
        @(posedge clk); #1;
        if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
    endtask

    task automatic wait_resp(input bit id, output int c);
        c = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (id ? resp1_valid : resp0_valid) begin c = cyc; break; end
        end
        if (c < 0) chk("resp_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!busy) return;
        end
        chk("idle_timeout", 0, 1);
    endtask

    task automatic sweep(input int k, input int lat);
        int t, c;
        logic [15:0] a, b;
        a = 16'($urandom);
        b = 16'($urandom);
        @(posedge clk); #1;
        sw_valid[k] = 1'b1; sw_a[k] = a; sw_b[k] = b;
        t = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (sw_ready[k]) begin t = cyc; break; end
        end
        if (t < 0) chk("sw_accept_timeout", 0, 1);
        @(posedge clk); #1;
        sw_valid[k] = 1'b0;
        @(negedge clk);
        chk("sw_start", sw_start[k], 1'b1);
        chk("sw_operands", {sw_mc[k], sw_mr[k]}, {a, b});
        c = -1;
        for (int i = 0; i < 300; i++) begin
            if (sw_v0[k]) begin c = cyc; break; end
            @(negedge clk);
        end
        chk("sw_latency", 64'(c - t), 64'(lat + 2));
        chk("sw_product0", sw_p0[k], smul(a, b));
        chk("sw_product1", sw_p1[k], smul(a, b));
        chk("sw_resp1_valid", sw_v1[k], 1'b0);
        chk("sw_req1_ready", sw_r1ready[k], 1'b0);
        @(negedge clk);
        chk("sw_idle", sw_busy[k], 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int t, c, h;
        for (int k = 0; k < 2; k++) begin
            sw_valid[k] = 1'b0; sw_a[k] = '0; sw_b[k] = '0;
        end
        // Reset with both requesters already asserting valid
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_a = 16'd11; req0_b = 16'd13; req1_a = 16'hFFF0; req1_b = 16'd3;
        resp0_ready = 1'b1; resp1_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_req0_ready", req0_ready, 1'b0);
        chk("rst_req1_ready", req1_ready, 1'b0);
        chk("rst_mul_start", mul_start, 1'b0);
        chk("rst_resp_valid", {resp0_valid, resp1_valid}, 2'b00);
        chk("rst_products", {resp0_product, resp1_product}, 66'd0);
        chk("rst_operands", {mul_multiplicand, mul_multiplicator}, 32'd0);

        // Tie with round-robin: expect 0,1,0,1 spaced L+3 apart
        log_id.delete(); log_cyc.delete();
        @(posedge clk); #2 rst = 1'b0;
        for (int i = 0; i < 200 && log_id.size() < 4; i++) @(negedge clk);
        @(posedge clk); #1 req0_valid = 1'b0; req1_valid = 1'b0;
        chk("rr_count", log_id.size() >= 4, 1'b1);
        for (int i = 0; i < 4 && i < log_id.size(); i++) begin
            chk("rr_order", log_id[i], i % 2);
            if (i > 0) chk("rr_spacing", 64'(log_cyc[i] - log_cyc[i-1]), 64'(L + 3));
        end
        wait_idle();

        // Single request 3*5
        do_req(1'b0, 16'd3, 16'd5, t);
        wait_resp(1'b0, c);
        chk("single_latency", 64'(c - t), 64'(L + 2));
        chk("single_product", resp0_product, 33'd15);
        chk("single_resp1", resp1_valid, 1'b0);
        wait_idle();

        // Signed operands on requester 1
        do_req(1'b1, 16'hFFFE, 16'd7, t);
        wait_resp(1'b1, c);
        chk("signed_product", resp1_product, 33'h1FFFFFFF2);
        chk("signed_resp0", resp0_valid, 1'b0);
        wait_idle();

        // Response backpressure with requester 1 waiting
        resp0_ready = 1'b0;
        do_req(1'b0, 16'hFFFD, 16'hFC18, t);
        req1_valid = 1'b1; req1_a = 16'd9; req1_b = 16'd9;
        wait_resp(1'b0, c);
        for (int i = 0; i < 10; i++) begin
            chk("bp_product", resp0_product, 33'd3000);
            chk("bp_busy", busy, 1'b1);
            chk("bp_req1_ready", req1_ready, 1'b0);
            @(negedge clk);
        end
        @(posedge clk); #1 resp0_ready = 1'b1;
        @(negedge clk);
        h = cyc;
        @(negedge clk);
        chk("bp_accept_next", req1_ready, 1'b1);
        chk("bp_accept_cycle", 64'(cyc - h), 64'd1);
        @(posedge clk); #1 req1_valid = 1'b0;
        wait_resp(1'b1, c);
        chk("bp_req1_product", resp1_product, 33'd81);
        wait_idle();

        // Asynchronous reset in WAIT (cnt = 5), then a clean operation
        do_req(1'b0, 16'd100, 16'hFFCE, t);
        repeat (12) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_start", mul_start, 1'b0);
        chk("midrst_resp_valid", {resp0_valid, resp1_valid}, 2'b00);
        chk("midrst_operands", {mul_multiplicand, mul_multiplicator}, 32'd0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        do_req(1'b1, 16'h8000, 16'h8000, t);
        wait_resp(1'b1, c);
        chk("post_rst_latency", 64'(c - t), 64'(L + 2));
        chk("post_rst_product", resp1_product, 33'h040000000);
        wait_idle();

        // Random traffic; the model checks every cycle
        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #1;
            req0_valid  = ($urandom % 3) != 0;
            req1_valid  = ($urandom % 3) != 0;
            req0_a      = 16'($urandom); req0_b = 16'($urandom);
            req1_a      = 16'($urandom); req1_b = 16'($urandom);
            resp0_ready = ($urandom % 2) != 0;
            resp1_ready = ($urandom % 2) != 0;
        end
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0; resp0_ready = 1'b1; resp1_ready = 1'b1;
        wait_idle();

        // Latency extremes
        sweep(0, 1);
        sweep(1, 255);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
